rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
//  Parametrised hh:mm:ss time-of-day counter driven from the system clock via an internal prescaler.
//  Supersedes the 1 Hz-clocked clock block. Adds: count enable, synchronous time load with range check,
//  12/24 h display mode, carry tick pulses, and an hh:mm alarm comparator.
//  Sits between the system clock domain and the display/alarm logic.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per second; legal range >= 1; 1 = advance every enabled cycle
//  PS_W      $clog2(TICK_DIV)>0 ? $clog2(TICK_DIV) : 1   prescaler width (derived, do not override)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset      in   1  reset, synchronous, active-high
//  en         in   1  count enable; 0 freezes prescaler and time
//  mode_12h   in   1  1 = 12 h display on disp_hours/pm; 0 = 24 h
//  set_valid  in   1  load set_hh/set_mm/set_ss this cycle
//  set_hh     in   5  load hours, 0-23
//  set_mm     in   6  load minutes, 0-59
//  set_ss     in   6  load seconds, 0-59
//  alarm_en   in   1  alarm compare enable
//  alarm_hh   in   5  alarm hours, 24 h, 0-23
//  alarm_mm   in   6  alarm minutes
//  seconds    out  6  current seconds, 0-59
//  minutes    out  6  current minutes, 0-59
//  hours      out  5  current hours, 24 h, 0-23
//  disp_hours out  5  0-23 (24 h) or 1-12 (12 h)
//  pm         out  1  1 when hours >= 12; valid in both modes
//  sec_tick   out  1  1-cycle pulse: seconds advanced
//  min_tick   out  1  1-cycle pulse: seconds wrapped 59->0
//  hour_tick  out  1  1-cycle pulse: minutes wrapped 59->0
//  day_tick   out  1  1-cycle pulse: 23:59:59 -> 00:00:00
//  alarm_hit  out  1  1-cycle pulse: tick reached alarm_hh:alarm_mm:00 with alarm_en=1
//  set_err    out  1  1-cycle pulse: set_valid with an out-of-range field; load discarded
// BEHAVIOUR
//  Reset
//   - prescaler, seconds, minutes, hours = 0; all pulse outputs = 0.
//   - disp_hours = 12 if mode_12h else 0; pm = 0.
//   - Reset overrides set_valid and en.
//  Prescaler
//   - When en=1, counts 0..TICK_DIV-1, then wraps to 0.
//   - The wrapping edge is the "tick edge"; en=0 holds prescaler and time.
//  Tick edge
//   - seconds+1. At 59: seconds=0 and minutes+1.
//   - At minutes 59: minutes=0 and hours+1. At hours 23: hours=0.
//   - No field ever holds 60/24.
//  Pulses
//   - Registered; high for exactly the cycle after the tick edge, coincident with the new time value.
//   - sec_tick on every tick. min_tick/hour_tick/day_tick nest: day_tick implies the other three.
//  Alarm
//   - alarm_hit = tick edge AND alarm_en AND new time == alarm_hh:alarm_mm:00.
//   - Fires once per day per match. Loads never raise alarm_hit.
//   - alarm_hh>23 or alarm_mm>59 never matches.
//  Load
//   - set_valid with all fields in range: time <= set values and prescaler <= 0 on that edge.
//   - Load wins over a coincident tick edge: no increment, no tick pulses. Load works with en=0.
//   - Any field out of range: time and prescaler unchanged (a coincident tick still proceeds); set_err=1 next cycle.
//  Display
//   - disp_hours/pm are combinational from hours and mode_12h.
//   - 12 h mapping: 0->12, 1-12->same, 13-23->h-12.
//  Latency: load and tick results visible 1 cycle after the triggering edge. Mode change takes effect immediately.
// TESTING
//  1 reset=1 mid-count at 12:34:56 -> next cycle all time 0, pulses 0, disp_hours=0 (mode_12h=0).
//  2 TICK_DIV=4, load 23:59:58, en=1 -> 23:59:59 after 4 clks; after 8 clks 00:00:00 + sec/min/hour/day_tick high 1 cycle.
//  3 TICK_DIV=4, en toggled 0 for 10 clks mid-second -> prescaler/time frozen; resume completes second with no lost or extra tick.
//  4 set 10:60:00 -> set_err pulse, time unchanged; set 13:05:07 on a tick edge -> 13:05:07, no sec_tick.
//  5 mode_12h=1 at hours 0, 12, 13 -> disp_hours/pm = 12/0, 12/1, 1/1.
//  6 alarm_en=1 07:30, load 07:29:59 -> alarm_hit 1 cycle at 07:30:00; alarm_en=0 repeat -> none; load 07:30:00 -> none.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss time-of-day counter with prescaler, validated time load, 12/24 h display,
// nested carry tick pulses and an hh:mm alarm comparator.
module rtc_timekeeper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PS_W     = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       set_err
);

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps;
    logic            tick;
    logic            set_ok;
    logic            sec_wrap;
    logic            min_wrap;
    logic            hr_wrap;
    logic [5:0]      nxt_ss;
    logic [5:0]      nxt_mm;
    logic [4:0]      nxt_hh;
    logic            alarm_match;

    assign tick   = en && (ps == PS_MAX);
    assign set_ok = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);

    // Carry chain evaluated from the current time; used for both the update and the alarm compare.
    assign sec_wrap = (seconds == 6'd59);
    assign min_wrap = sec_wrap && (minutes == 6'd59);
    assign hr_wrap  = min_wrap && (hours == 5'd23);

    assign nxt_ss = sec_wrap ? 6'd0 : seconds + 6'd1;
    assign nxt_mm = sec_wrap ? ((minutes == 6'd59) ? 6'd0 : minutes + 6'd1) : minutes;
    assign nxt_hh = min_wrap ? ((hours == 5'd23) ? 5'd0 : hours + 5'd1) : hours;

    // Out-of-range alarm settings can never equal an in-range next time, so they never match.
    assign alarm_match = (nxt_hh == alarm_hh) && (nxt_mm == alarm_mm) && (nxt_ss == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ps        <= '0;
            seconds   <= '0;
            minutes   <= '0;
            hours     <= '0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= set_valid && !set_ok;
            if (set_valid && set_ok) begin
                ps      <= '0;
                seconds <= set_ss;
                minutes <= set_mm;
                hours   <= set_hh;
            end else if (tick) begin
                ps        <= '0;
                seconds   <= nxt_ss;
                minutes   <= nxt_mm;
                hours     <= nxt_hh;
                sec_tick  <= 1'b1;
                min_tick  <= sec_wrap;
                hour_tick <= min_wrap;
                day_tick  <= hr_wrap;
                alarm_hit <= alarm_en && alarm_match;
            end else if (en) begin
                ps <= ps + 1'b1;
            end
        end
    end

    always_comb begin
        pm         = (hours >= 5'd12);
        disp_hours = hours;
        if (mode_12h) begin
            if (hours == 5'd0)
                disp_hours = 5'd12;
            else if (hours > 5'd12)
                disp_hours = hours - 5'd12;
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with a 4-cycle prescaler.
module tb_rtc_timekeeper;

    logic       clk = 1'b0;
    logic       reset, en, mode_12h, set_valid, alarm_en;
    logic [4:0] set_hh, alarm_hh;
    logic [5:0] set_mm, set_ss, alarm_mm;
    logic [5:0] seconds, minutes;
    logic [4:0] hours, disp_hours;
    logic       pm, sec_tick, min_tick, hour_tick, day_tick, alarm_hit, set_err;

    int n_cmp = 0;
    int n_bad = 0;

    rtc_timekeeper #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode_12h(mode_12h),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .disp_hours(disp_hours), .pm(pm),
        .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick),
        .alarm_hit(alarm_hit), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s;
        step(1);
        set_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        n_cmp++;
        if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd0}) begin
            n_bad++;
            $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        reset = 1'b0;
        do_load(5'd12, 6'd34, 6'd56);
        en = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        n_cmp++;
        if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd0}) begin
            n_bad++;
            $display("FAIL reset_midcount: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        n_cmp++;
        if ({sec_tick, min_tick, hour_tick, day_tick, alarm_hit, set_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b want 000000",
                     {sec_tick, min_tick, hour_tick, day_tick, alarm_hit, set_err});
        end
        n_cmp++;
        if ({disp_hours, pm} !== {5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_disp24: got %0d/%0d want 0/0", disp_hours, pm);
        end
        mode_12h = 1'b1;
        #1;
        n_cmp++;
        if ({disp_hours, pm} !== {5'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_disp12: got %0d/%0d want 12/0", disp_hours, pm);
        end
        mode_12h = 1'b0;
        en = 1'b0;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_rollover;
        do_load(5'd23, 6'd59, 6'd58);
        en = 1'b1;
        step(3);
        n_cmp++;
        if ({hours, minutes, seconds, sec_tick} !== {5'd23, 6'd59, 6'd58, 1'b0}) begin
            n_bad++;
            $display("FAIL roll_pre: got %0d:%0d:%0d tick=%0d want 23:59:58 tick=0",
                     hours, minutes, seconds, sec_tick);
        end
        step(1);
        n_cmp++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
            n_bad++;
            $display("FAIL roll_59: got %0d:%0d:%0d want 23:59:59", hours, minutes, seconds);
        end
        n_cmp++;
        if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b1000) begin
            n_bad++;
            $display("FAIL roll_59_ticks: got %b want 1000", {sec_tick, min_tick, hour_tick, day_tick});
        end
        step(4);
        n_cmp++;
        if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd0}) begin
            n_bad++;
            $display("FAIL roll_day: got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        n_cmp++;
        if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b1111) begin
            n_bad++;
            $display("FAIL roll_day_ticks: got %b want 1111", {sec_tick, min_tick, hour_tick, day_tick});
        end
        step(1);
        n_cmp++;
        if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b0000) begin
            n_bad++;
            $display("FAIL roll_ticks_clear: got %b want 0000", {sec_tick, min_tick, hour_tick, day_tick});
        end
    endtask

    task automatic test_enable;
        do_load(5'd1, 6'd2, 6'd3);
        step(2);
        en = 1'b0;
        step(10);
        n_cmp++;
        if ({hours, minutes, seconds, sec_tick} !== {5'd1, 6'd2, 6'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL en_freeze: got %0d:%0d:%0d tick=%0d want 1:2:3 tick=0",
                     hours, minutes, seconds, sec_tick);
        end
        en = 1'b1;
        step(1);
        n_cmp++;
        if ({seconds, sec_tick} !== {6'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL en_resume_early: got sec=%0d tick=%0d want sec=3 tick=0", seconds, sec_tick);
        end
        step(1);
        n_cmp++;
        if ({seconds, sec_tick} !== {6'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL en_resume_tick: got sec=%0d tick=%0d want sec=4 tick=1", seconds, sec_tick);
        end
        step(3);
        n_cmp++;
        if ({seconds, sec_tick} !== {6'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL en_next_early: got sec=%0d tick=%0d want sec=4 tick=0", seconds, sec_tick);
        end
        step(1);
        n_cmp++;
        if ({seconds, sec_tick} !== {6'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL en_next_tick: got sec=%0d tick=%0d want sec=5 tick=1", seconds, sec_tick);
        end
    endtask

    task automatic test_load;
        en = 1'b0;
        do_load(5'd10, 6'd60, 6'd0);
        n_cmp++;
        if ({hours, minutes, seconds, set_err} !== {5'd1, 6'd2, 6'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL load_bad_min: got %0d:%0d:%0d err=%0d want 1:2:5 err=1",
                     hours, minutes, seconds, set_err);
        end
        step(1);
        n_cmp++;
        if (set_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err_clear: got %0d want 0", set_err);
        end
        do_load(5'd24, 6'd0, 6'd0);
        n_cmp++;
        if ({hours, set_err} !== {5'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL load_bad_hr: got h=%0d err=%0d want h=1 err=1", hours, set_err);
        end
        do_load(5'd0, 6'd0, 6'd0);
        en = 1'b1;
        step(3);
        do_load(5'd13, 6'd5, 6'd7);
        n_cmp++;
        if ({hours, minutes, seconds, sec_tick, set_err} !== {5'd13, 6'd5, 6'd7, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_on_tick: got %0d:%0d:%0d tick=%0d err=%0d want 13:5:7 tick=0 err=0",
                     hours, minutes, seconds, sec_tick, set_err);
        end
        step(3);
        n_cmp++;
        if (seconds !== 6'd7) begin
            n_bad++;
            $display("FAIL load_ps_cleared: got sec=%0d want 7", seconds);
        end
        step(1);
        n_cmp++;
        if ({seconds, sec_tick} !== {6'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL load_after_tick: got sec=%0d tick=%0d want 8/1", seconds, sec_tick);
        end
        step(3);
        do_load(5'd25, 6'd0, 6'd0);
        n_cmp++;
        if ({hours, minutes, seconds, sec_tick, set_err} !== {5'd13, 6'd5, 6'd9, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL badload_on_tick: got %0d:%0d:%0d tick=%0d err=%0d want 13:5:9 tick=1 err=1",
                     hours, minutes, seconds, sec_tick, set_err);
        end
        en = 1'b0;
    endtask

    task automatic test_display;
        logic [4:0] h_tab [6] = '{5'd0, 5'd12, 5'd13, 5'd23, 5'd11, 5'd1};
        logic [4:0] d_tab [6] = '{5'd12, 5'd12, 5'd1, 5'd11, 5'd11, 5'd1};
        logic       p_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        en = 1'b0;
        mode_12h = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_load(h_tab[i], 6'd0, 6'd0);
            n_cmp++;
            if ({disp_hours, pm} !== {d_tab[i], p_tab[i]}) begin
                n_bad++;
                $display("FAIL disp12_h%0d: got %0d/%0d want %0d/%0d",
                         h_tab[i], disp_hours, pm, d_tab[i], p_tab[i]);
            end
        end
        do_load(5'd13, 6'd0, 6'd0);
        mode_12h = 1'b0;
        #1;
        n_cmp++;
        if ({disp_hours, pm} !== {5'd13, 1'b1}) begin
            n_bad++;
            $display("FAIL disp24_h13: got %0d/%0d want 13/1", disp_hours, pm);
        end
    endtask

    task automatic test_alarm;
        alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_en = 1'b1;
        en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        en = 1'b1;
        step(3);
        n_cmp++;
        if (alarm_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_early: got %0d want 0", alarm_hit);
        end
        step(1);
        n_cmp++;
        if ({hours, minutes, seconds, alarm_hit, min_tick} !== {5'd7, 6'd30, 6'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL alarm_hit: got %0d:%0d:%0d hit=%0d min=%0d want 7:30:0 hit=1 min=1",
                     hours, minutes, seconds, alarm_hit, min_tick);
        end
        step(1);
        n_cmp++;
        if (alarm_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_pulse_len: got %0d want 0", alarm_hit);
        end
        alarm_en = 1'b0;
        en = 1'b0;
        do_load(5'd7, 6'd29, 6'd59);
        en = 1'b1;
        step(4);
        n_cmp++;
        if ({minutes, alarm_hit} !== {6'd30, 1'b0}) begin
            n_bad++;
            $display("FAIL alarm_disabled: got min=%0d hit=%0d want 30/0", minutes, alarm_hit);
        end
        alarm_en = 1'b1;
        en = 1'b0;
        do_load(5'd7, 6'd30, 6'd0);
        n_cmp++;
        if (alarm_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_on_load: got %0d want 0", alarm_hit);
        end
        en = 1'b1;
        step(4);
        n_cmp++;
        if ({seconds, alarm_hit} !== {6'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL alarm_after_load: got sec=%0d hit=%0d want 1/0", seconds, alarm_hit);
        end
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
        set_hh = '0; set_mm = '0; set_ss = '0;
        alarm_en = 1'b0; alarm_hh = '0; alarm_mm = '0;
        test_reset();
        test_rollover();
        test_enable();
        test_load();
        test_display();
        test_alarm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
